// File: rtl/countdown_ctrl.sv
// Four-digit BCD countdown controller with load/start/pause and one-shot expiry.
// Optional display blink in HOLD/EXPIRED is enabled with macro COUNTDOWN_CTRL_BLINK_EN.
module countdown_ctrl #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic [15:0] preset,
    output logic [15:0] digits,
    output logic        busy,
    output logic        expired,
    output logic        done,
    output logic        blank
);
    // state   | meaning
    // IDLE    | after reset, waiting for load
    // ARMED   | preset captured, waiting for start
    // RUN     | prescaler running, decrement at terminal count
    // HOLD    | paused, prescaler frozen
    // EXPIRED | count reached 0000, held until load
    typedef enum logic [2:0] {IDLE, ARMED, RUN, HOLD, EXPIRED} state_t;

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

    state_t        state, state_nxt;
    logic [15:0]   digits_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          done_nxt;
    logic [15:0]   dec_val;

    function automatic logic [15:0] sat_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign dec_val = bcd_dec(digits);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            digits  <= 16'h0000;
            presc   <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            digits  <= digits_nxt;
            presc   <= presc_nxt;
            done    <= done_nxt;
            busy    <= (state_nxt == RUN) || (state_nxt == HOLD);
            expired <= (state_nxt == EXPIRED);
        end
    end

    // Leaving HOLD with pause low counts on that same edge, so the frozen
    // prescaler picks up exactly where it stopped.
    always_comb begin
        state_nxt  = state;
        digits_nxt = digits;
        presc_nxt  = presc;
        done_nxt   = 1'b0;
        if (load) begin
            state_nxt  = ARMED;
            digits_nxt = sat_bcd(preset);
            presc_nxt  = '0;
        end else begin
            case (state)
                ARMED: begin
                    if (start) begin
                        presc_nxt = '0;
                        if (digits == 16'h0000) begin
                            state_nxt = EXPIRED;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                RUN, HOLD: begin
                    if (pause) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RUN;
                        if (presc == TC) begin
                            presc_nxt  = '0;
                            digits_nxt = dec_val;
                            if (dec_val == 16'h0000) begin
                                state_nxt = EXPIRED;
                                done_nxt  = 1'b1;
                            end
                        end else begin
                            presc_nxt = presc + PW'(1);
                        end
                    end
                end
                EXPIRED: digits_nxt = 16'h0000;
                default: ;
            endcase
        end
    end

`ifdef COUNTDOWN_CTRL_BLINK_EN
    logic [PW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blank_nxt;

    always_comb begin
        blink_cnt_nxt = '0;
        blank_nxt     = 1'b0;
        if ((state_nxt == HOLD || state_nxt == EXPIRED) && (state_nxt == state)) begin
            if (blink_cnt == TC) begin
                blank_nxt = ~blank;
            end else begin
                blink_cnt_nxt = blink_cnt + PW'(1);
                blank_nxt     = blank;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            blank     <= blank_nxt;
        end
    end
`else
    assign blank = 1'b0;
`endif

endmodule
